// File: rtl/product_accumulator.sv
// Sums a run of LEN unsigned products from the approximate multiplier into a
// saturating accumulator. The result is held on a valid/ready port with a sticky overflow flag.
module product_accumulator #(
  parameter int unsigned PROD_WIDTH = 24,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] prod_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic                  ovf_o
);

  localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 stateNext;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   accNext;
  logic                   ovf;
  logic                   ovfNext;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cntNext;
  logic [CNT_WIDTH-1:0]   lenQ;
  logic [CNT_WIDTH-1:0]   lenNext;
  logic                   readyNext;
  logic                   validNext;

  logic                   transferIn;
  logic                   transferOut;
  logic [SUM_WIDTH-1:0]   sumWide;
  logic [CNT_WIDTH-1:0]   cntInc;
  logic [CNT_WIDTH-1:0]   lenFirst;

  assign transferIn  = in_valid & in_ready;
  assign transferOut = out_valid & out_ready;
  // One extra bit catches the carry that signals saturation.
  assign sumWide     = SUM_WIDTH'(acc) + SUM_WIDTH'(prod_i);
  assign cntInc      = cnt + CNT_WIDTH'(1);
  assign lenFirst    = (len_i == '0) ? CNT_WIDTH'(1) : len_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (transferIn) begin
          stateNext = (lenFirst == CNT_WIDTH'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (transferIn && (cntInc == lenQ)) begin
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (transferOut) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Accumulator datapath next values
  always_comb begin
    accNext = acc;
    ovfNext = ovf;
    cntNext = cnt;
    lenNext = lenQ;
    case (state)
      IDLE: begin
        if (transferIn) begin
          accNext = ACC_WIDTH'(prod_i);
          ovfNext = 1'b0;
          cntNext = CNT_WIDTH'(1);
          lenNext = lenFirst;
        end
      end
      ACCUM: begin
        if (transferIn) begin
          if (sumWide[ACC_WIDTH]) begin
            accNext = '1;
            ovfNext = 1'b1;
          end else begin
            accNext = sumWide[ACC_WIDTH-1:0];
          end
          cntNext = cntInc;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      ovf  <= 1'b0;
      cnt  <= '0;
      lenQ <= '0;
    end else begin
      acc  <= accNext;
      ovf  <= ovfNext;
      cnt  <= cntNext;
      lenQ <= lenNext;
    end
  end

  // Handshake outputs follow the upcoming state so they come straight from flops.
  always_comb begin
    readyNext = (stateNext != HOLD);
    validNext = (stateNext == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= readyNext;
      out_valid <= validNext;
    end
  end

  assign acc_o = acc;
  assign ovf_o = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 24-bit accumulator instance exercises saturation,
// and a default 32-bit instance runs alongside it on the same stimulus.
`timescale 1ns/1ps
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic [7:0]  len_i;
  logic        in_valid;
  logic [23:0] prod_i;
  logic        out_ready;

  logic        inReady24;
  logic        outValid24;
  logic [23:0] acc24;
  logic        ovf24;
  logic        inReady32;
  logic        outValid32;
  logic [31:0] acc32;
  logic        ovf32;

  int errors = 0;
  int checks = 0;

  product_accumulator #(.PROD_WIDTH(24), .ACC_WIDTH(24), .CNT_WIDTH(8)) u24 (
    .clk(clk), .rst(rst), .len_i(len_i), .in_valid(in_valid), .in_ready(inReady24),
    .prod_i(prod_i), .out_valid(outValid24), .out_ready(out_ready),
    .acc_o(acc24), .ovf_o(ovf24)
  );

  product_accumulator u32 (
    .clk(clk), .rst(rst), .len_i(len_i), .in_valid(in_valid), .in_ready(inReady32),
    .prod_i(prod_i), .out_valid(outValid32), .out_ready(out_ready),
    .acc_o(acc32), .ovf_o(ovf32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0]       len;
    logic [2:0]       n;
    logic [3:0][23:0] p;
    logic [23:0]      a24;
    logic             o24;
    logic [31:0]      a32;
    logic             o32;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one product and hold it until an edge where in_ready was high.
  task automatic sendProduct(input logic [7:0] len, input logic [23:0] p);
    bit accepted;
    accepted = 1'b0;
    len_i    = len;
    prod_i   = p;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      accepted = inReady24;
      step();
    end
    in_valid = 1'b0;
    check("send accepted", 64'(accepted), 64'd1);
  endtask

  // Wait for a result, optionally stall it, compare both instances, then take it.
  task automatic collect(input string name, input logic [23:0] e24, input logic eo24,
                         input logic [31:0] e32, input logic eo32, input int stall);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (outValid24) got = 1'b1;
      else step();
    end
    check({name, " out_valid"}, 64'(got), 64'd1);
    repeat (stall) step();
    check({name, " valid24"}, 64'(outValid24), 64'd1);
    check({name, " acc24"}, 64'(acc24), 64'(e24));
    check({name, " ovf24"}, 64'(ovf24), 64'(eo24));
    check({name, " valid32"}, 64'(outValid32), 64'd1);
    check({name, " acc32"}, 64'(acc32), 64'(e32));
    check({name, " ovf32"}, 64'(ovf32), 64'(eo32));
    check({name, " ready in hold"}, 64'(inReady24), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, " valid cleared"}, 64'(outValid24), 64'd0);
  endtask

  function automatic vec_t mk(input logic [7:0] len, input logic [2:0] n,
                              input logic [23:0] p0, input logic [23:0] p1,
                              input logic [23:0] p2, input logic [23:0] p3,
                              input logic [23:0] a24, input logic o24,
                              input logic [31:0] a32, input logic o32);
    vec_t v;
    v.len = len; v.n = n;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    v.a24 = a24; v.o24 = o24; v.a32 = a32; v.o32 = o32;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    int vals[4];
    bit pat[6];
    int k;
    vecs[0] = mk(8'd4, 3'd4, 24'd100, 24'd200, 24'd300, 24'd400, 24'd1000, 1'b0, 32'd1000, 1'b0);
    vecs[1] = mk(8'd0, 3'd1, 24'hFFFFFF, 0, 0, 0, 24'hFFFFFF, 1'b0, 32'h00FFFFFF, 1'b0);
    vecs[2] = mk(8'd3, 3'd3, 24'hFFFFFF, 24'd1, 24'd5, 0, 24'hFFFFFF, 1'b1, 32'h01000005, 1'b0);
    vecs[3] = mk(8'd1, 3'd1, 24'd7, 0, 0, 0, 24'd7, 1'b0, 32'd7, 1'b0);
    vecs[4] = mk(8'd2, 3'd2, 24'h800000, 24'h800000, 0, 0, 24'hFFFFFF, 1'b1, 32'h01000000, 1'b0);
    vecs[5] = mk(8'd2, 3'd2, 24'h7FFFFF, 24'h800000, 0, 0, 24'hFFFFFF, 1'b0, 32'h00FFFFFF, 1'b0);
    vecs[6] = mk(8'd4, 3'd4, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 24'hFFFFFF, 1'b1, 32'h01FFFFFE, 1'b0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; len_i = '0; prod_i = '0;
    step(); step();
    check("reset in_ready", 64'(inReady24), 64'd0);
    check("reset out_valid", 64'(outValid24), 64'd0);
    check("reset acc", 64'(acc24), 64'd0);
    check("reset ovf", 64'(ovf24), 64'd0);
    rst = 1'b0;
    step();
    check("post-reset in_ready24", 64'(inReady24), 64'd1);
    check("post-reset in_ready32", 64'(inReady32), 64'd1);

    // Reset in the middle of a run discards the partial sum.
    sendProduct(8'd8, 24'd11); sendProduct(8'd8, 24'd12); sendProduct(8'd8, 24'd13);
    rst = 1'b1;
    step();
    check("midrun reset in_ready", 64'(inReady24), 64'd0);
    step();
    rst = 1'b0;
    step();
    check("midrun out_valid", 64'(outValid24), 64'd0);
    check("midrun acc", 64'(acc24), 64'd0);
    check("midrun in_ready", 64'(inReady24), 64'd1);
    sendProduct(8'd1, 24'd9);
    collect("after reset run", 24'd9, 1'b0, 32'd9, 1'b0, 0);

    // Back-to-back run with exact result timing.
    vals = '{100, 200, 300, 400};
    len_i = 8'd4; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prod_i = 24'(vals[i]);
      check("b2b in_ready", 64'(inReady24), 64'd1);
      check("b2b no early valid", 64'(outValid24), 64'd0);
      step();
    end
    in_valid = 1'b0;
    check("b2b out_valid", 64'(outValid24), 64'd1);
    check("b2b acc", 64'(acc24), 64'd1000);
    check("b2b ovf", 64'(ovf24), 64'd0);
    check("b2b hold ready", 64'(inReady24), 64'd0);
    step();
    out_ready = 1'b0;
    check("b2b idle valid", 64'(outValid24), 64'd0);
    check("b2b idle ready", 64'(inReady24), 64'd1);

    // Table of runs.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < int'(vecs[v].n); i++) sendProduct(vecs[v].len, vecs[v].p[i]);
      collect($sformatf("vec%0d", v), vecs[v].a24, vecs[v].o24, vecs[v].a32, vecs[v].o32, 0);
    end

    // Backpressure: result stays put and no product is taken while held.
    sendProduct(8'd2, 24'd3);
    sendProduct(8'd2, 24'd4);
    in_valid = 1'b1; prod_i = 24'd99;
    for (int i = 0; i < 5; i++) begin
      check("bp valid", 64'(outValid24), 64'd1);
      check("bp acc", 64'(acc24), 64'd7);
      check("bp ready", 64'(inReady24), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp released", 64'(outValid24), 64'd0);
    check("bp ready back", 64'(inReady24), 64'd1);
    sendProduct(8'd1, 24'd5);
    collect("bp next run", 24'd5, 1'b0, 32'd5, 1'b0, 0);

    // Gapped input; len_i changes after the first product are ignored.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vals = '{10, 20, 30, 0};
    k = 0;
    len_i = 8'd3;
    for (int c = 0; c < 6; c++) begin
      in_valid = pat[c];
      prod_i = 24'(vals[k]);
      if (c > 0) len_i = 8'd1;
      step();
      if (pat[c]) k++;
    end
    in_valid = 1'b0;
    collect("gapped", 24'd60, 1'b0, 32'd60, 1'b0, 0);

    // Randomized runs against a saturating-sum model.
    for (int r = 0; r < 200; r++) begin
      int len;
      int n;
      longint unsigned s24, s32, t;
      bit o24, o32;
      logic [23:0] p;
      len = int'($urandom_range(0, 6));
      n = (len == 0) ? 1 : len;
      s24 = 0; s32 = 0; o24 = 0; o32 = 0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) p = 24'(32'hFFFFFF - $urandom_range(0, 15));
        else p = 24'($urandom);
        repeat ($urandom_range(0, 2)) step();
        sendProduct((i == 0) ? 8'(len) : 8'($urandom), p);
        if (i < n - 1) check("rand no early valid", 64'(outValid24), 64'd0);
        if (i == 0) begin
          s24 = longint'(p); s32 = longint'(p);
        end else begin
          t = s24 + longint'(p);
          if (t > 64'hFFFFFF) begin s24 = 64'hFFFFFF; o24 = 1; end else s24 = t;
          t = s32 + longint'(p);
          if (t > 64'hFFFFFFFF) begin s32 = 64'hFFFFFFFF; o32 = 1; end else s32 = t;
        end
      end
      collect("rand", 24'(s24), o24, 32'(s32), o32, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
